mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/HI/LO width (only 32 verified).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation (one-cycle strobe).
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port A, B  input  32 each  operands (rs, rt); B is the divisor.
REQ-007 SHALL have port wr_hi, wr_lo  input  1 each  MTHI/MTLO write strobes.
REQ-008 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-009 SHALL have port hi, lo  output  32 each  HI/LO registers (MFHI/MFLO source).
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; hi/lo hold the new result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE.
REQ-013 In IDLE, start=1 SHALL capture A, B, op, the operand signs and the magnitudes (signed ops only), clear the iteration counter, and go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-014 start SHALL be ignored in every state except IDLE and DONE; in DONE it is accepted as in IDLE.
REQ-015 MUL SHALL run 32 cycles of radix-2 shift-add on the magnitudes into a 64-bit accumulator.
REQ-016 DIV SHALL run 32 cycles of restoring division, producing a 32-bit quotient and a 32-bit remainder.
REQ-017 After cycle 32 the FSM SHALL enter FIX for one cycle and write hi/lo.
REQ-018 FIX, multiply: signed product negated when sign(A)^sign(B) = 1; hi = product[63:32], lo = product[31:0].
REQ-019 FIX, divide: lo = quotient, negated when sign(A)^sign(B); hi = remainder, negated when sign(A); i.e. truncation toward zero.
REQ-020 DIV/DIVU with B=0 SHALL skip iteration and go directly to FIX; hi = A, lo = 32'hFFFFFFFF.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0, with no flag.
REQ-022 Latency, start sampled at edge 0: busy = 1 after edge 1 through FIX; done = 1 for exactly the cycle after FIX (DONE state); normal result at edge 34, divide-by-zero at edge 2.
REQ-023 DONE SHALL return to IDLE on the next edge unless start is accepted.
REQ-024 hi/lo SHALL change only in FIX, or on wr_hi/wr_lo.
REQ-025 wr_hi/wr_lo SHALL be ignored while busy = 1.
REQ-026 When not busy, wr_hi/wr_lo SHALL load wdata on the next edge.
REQ-027 Simultaneous start and wr_* in IDLE: the write SHALL take effect and the operation SHALL start; FIX later overwrites both hi and lo.

Reset
REQ-028 rst = 1 SHALL immediately force: FSM IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
REQ-029 rst = 1 mid-operation SHALL abort the operation with no partial write to hi/lo.
REQ-030 start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-031 Macro MDU_DIV_EN SHALL select division support.
REQ-032 With MDU_DIV_EN defined, DIV/DIVU SHALL behave per REQ-016/019/020/021.
REQ-033 Without MDU_DIV_EN, the divider datapath SHALL be absent.
REQ-034 Without MDU_DIV_EN, DIV/DIVU SHALL go straight to FIX and write hi = lo = 32'hDEADBEEF, with done at edge 2.

Structure
REQ-035 Package mdu_pkg SHALL hold: op encodings, the FSM state typedef, the iteration count (32), DIV0_LO = 32'hFFFFFFFF, NODIV_VAL = 32'hDEADBEEF.
REQ-036 One sub-module, mdu_sign_fix, SHALL be used: combinational absolute-value/conditional-negate helper, used at capture and in FIX.

Verification
REQ-037 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done at edge 34, busy low after it.
REQ-038 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-040 DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF; done at edge 2 (without MDU_DIV_EN: both 0xDEADBEEF).
REQ-041 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-042 MULT started, rst pulsed at edge 10 -> busy=0, hi=lo=0 at once; wr_lo while busy ignored; new start after reset completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
// Division support is selected by the MDU_DIV_EN macro in mult_div_unit.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } mdu_state_e;

    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT + 1);

    localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;
    localparam logic [31:0] NODIV_VAL = 32'hDEADBEEF;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: absolute value at capture, sign restore at fix-up.
module mdu_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = val;
        if (neg) begin
            res = ~val + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit with MTHI/MTLO write port.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU return NODIV_VAL.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   bmag_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              is_div_q;

    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod_fixed;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = op_signed & A[XLEN-1];
    assign b_neg     = op_signed & B[XLEN-1];

    mdu_sign_fix #(.WIDTH(XLEN)) u_abs_a (.val(A), .neg(a_neg), .res(a_mag));
    mdu_sign_fix #(.WIDTH(XLEN)) u_abs_b (.val(B), .neg(b_neg), .res(b_mag));
    mdu_sign_fix #(.WIDTH(2*XLEN)) u_fix_prod (
        .val(acc_q),
        .neg(sign_a_q ^ sign_b_q),
        .res(prod_fixed)
    );

    // acc holds {partial product, remaining multiplier bits}; one bit retires per cycle.
    assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, bmag_q};
    assign mul_next = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

`ifdef MDU_DIV_EN
    logic [XLEN-1:0]   a_q;
    logic              b_zero_q;
    logic [XLEN:0]     shifted;
    logic              sub_ok;
    logic [XLEN-1:0]   sub_res;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quot_fixed;
    logic [XLEN-1:0]   rem_fixed;

    // acc holds {remainder, dividend bits shifting into quotient}.
    assign shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign sub_ok   = shifted >= {1'b0, bmag_q};
    assign sub_res  = shifted[XLEN-1:0] - bmag_q;
    assign div_next = sub_ok ? {sub_res, acc_q[XLEN-2:0], 1'b1}
                             : {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    mdu_sign_fix #(.WIDTH(XLEN)) u_fix_quot (
        .val(acc_q[XLEN-1:0]),
        .neg(sign_a_q ^ sign_b_q),
        .res(quot_fixed)
    );
    mdu_sign_fix #(.WIDTH(XLEN)) u_fix_rem (
        .val(acc_q[2*XLEN-1:XLEN]),
        .neg(sign_a_q),
        .res(rem_fixed)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MDU_DIV_EN
            a_q      <= '0;
            b_zero_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (wr_hi) hi <= wdata;
                if (wr_lo) lo <= wdata;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (start) begin
                        acc_q    <= {{XLEN{1'b0}}, a_mag};
                        bmag_q   <= b_mag;
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        is_div_q <= op[1];
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= op[1] ? StDiv : StMul;
`ifdef MDU_DIV_EN
                        a_q      <= A;
                        b_zero_q <= (B == '0);
`endif
                    end
                end
                StMul: begin
                    if (cnt_q == CNT_W'(ITER_COUNT)) begin
                        state_q <= StFix;
                    end else begin
                        acc_q <= mul_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDiv: begin
`ifdef MDU_DIV_EN
                    if (b_zero_q || cnt_q == CNT_W'(ITER_COUNT)) begin
                        state_q <= StFix;
                    end else begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`else
                    state_q <= StFix;
`endif
                end
                StFix: begin
                    if (!is_div_q) begin
                        hi <= prod_fixed[2*XLEN-1:XLEN];
                        lo <= prod_fixed[XLEN-1:0];
                    end else begin
`ifdef MDU_DIV_EN
                        if (b_zero_q) begin
                            hi <= a_q;
                            lo <= DIV0_LO;
                        end else begin
                            hi <= rem_fixed;
                            lo <= quot_fixed;
                        end
`else
                        hi <= NODIV_VAL;
                        lo <= NODIV_VAL;
`endif
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random operations
// checked against an arithmetic reference model (honours MDU_DIV_EN).
module tb_mult_div_unit;
    import mdu_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .wr_hi(wr_hi),
        .wr_lo(wr_lo),
        .wdata(wdata),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o == OP_MULT) begin
            res = 64'(sa * sb);
        end else if (o == OP_MULTU) begin
            res = 64'(ua * ub);
        end else if (!DIV_EN) begin
            res = {NODIV_VAL, NODIV_VAL};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFFFFFF};
        end else if (o == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    // Issues one operation from IDLE/DONE and checks latency, result and handshake.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy, input bit with_wr, input string tag);
        logic [63:0] exp_v;
        int lat;
        int edges;
        bit seen;
        exp_v = model(o, a, b);
        lat   = (o[1] && (!DIV_EN || b == 32'd0)) ? 2 : 34;
        edges = 0;
        seen  = 1'b0;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        if (with_wr) begin
            wr_hi = 1'b1;
            wr_lo = 1'b1;
            wdata = 32'hC0FFEE11;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        A     = $urandom();
        B     = $urandom();
        if (with_wr) begin
            check({tag, " wr_hi with start"}, hi, 32'hC0FFEE11);
            check({tag, " wr_lo with start"}, lo, 32'hC0FFEE11);
        end
        while (!seen && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
            end else if (noisy) begin
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                wr_hi = 1'($urandom_range(0, 1));
                wr_lo = 1'($urandom_range(0, 1));
                wdata = $urandom();
            end
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check({tag, " latency"}, 32'(edges), 32'(lat));
        check({tag, " hi"}, hi, exp_v[63:32]);
        check({tag, " lo"}, lo, exp_v[31:0]);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        #12;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "multu max");
        check("multu max hi const", hi, 32'hFFFFFFFE);
        check("multu max lo const", lo, 32'h00000001);
        @(posedge clk);
        #1;
        check("done one cycle", 32'(done), 32'd0);
        check("idle busy", 32'(busy), 32'd0);

        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, "mult -3*7");
        check("mult -3*7 lo const", lo, 32'hFFFFFFEB);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div -7/2");
        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0, "divu 7/2");
        run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, "divu 100/0");
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div ovf");
        run_op(OP_MULT, 32'h80000000, 32'h80000000, 1'b1, 1'b0, "mult minneg");

        // MTHI/MTLO while idle.
        @(negedge clk);
        wr_hi = 1'b1;
        wdata = 32'hAAAA5555;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        wr_lo = 1'b0;
        check("mthi", hi, 32'hAAAA5555);
        check("mtlo", lo, 32'h12345678);

        // Abort by reset mid-multiply, with an ignored MTLO while busy.
        op    = OP_MULT;
        A     = 32'd1234;
        B     = 32'd5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_lo = 1'b1;
        wdata = 32'hBADBAD00;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo ignored busy", lo, 32'h12345678);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_MULT, 32'd1234, 32'hFFFFFFFE, 1'b0, 1'b0, "after reset");

        run_op(OP_MULTU, 32'd6, 32'd9, 1'b0, 1'b1, "start+wr");

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
